// File: rtl/root_result_collector_pkg.sv
// Shared types and constants for the quadric root result collector.
// Holds the IEEE double helpers used to classify and order roots.
package root_result_collector_pkg;

    // Matches the IEEE double width used by UCBRecodedFloat.
    localparam int IEEE_argWidth = 64;

    localparam logic [10:0]              IEEE_EXP_ALL1 = 11'h7FF;
    localparam logic [IEEE_argWidth-1:0] IEEE_NAN_Q    = 64'h7FF8000000000000;

    typedef struct packed {
        logic                     hit;
        logic [IEEE_argWidth-1:0] near;
        logic [IEEE_argWidth-1:0] far;
    } RootResult;

    function automatic logic is_nan(input logic [IEEE_argWidth-1:0] b);
        return (b[62:52] == IEEE_EXP_ALL1) && (b[51:0] != '0);
    endfunction

    // Maps IEEE bits onto an unsigned key that sorts like the real value.
    function automatic logic [IEEE_argWidth-1:0] order_key(input logic [IEEE_argWidth-1:0] b);
        return b[63] ? ~b : (b | {1'b1, 63'b0});
    endfunction

endpackage

// File: rtl/root_result_collector_if.sv
// Root stream interface: intersector-side strobe plus the valid/ready result port.
interface root_result_collector_if;
    import root_result_collector_pkg::*;

    logic                     rootsValid;
    logic [IEEE_argWidth-1:0] leftRoot;
    logic [IEEE_argWidth-1:0] rightRoot;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_hit;
    logic [IEEE_argWidth-1:0] out_near;
    logic [IEEE_argWidth-1:0] out_far;

    modport master (
        output rootsValid, leftRoot, rightRoot, out_ready,
        input  out_valid, out_hit, out_near, out_far
    );

    modport slave (
        input  rootsValid, leftRoot, rightRoot, out_ready,
        output out_valid, out_hit, out_near, out_far
    );

endinterface

// File: rtl/root_result_collector_fifo.sv
// Synchronous FIFO with flush; head is read straight from storage.
// Occupancy comes from write/read counters carrying one extra MSB.
module root_fifo
    import root_result_collector_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter type T     = RootResult
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clear,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  T                       i_din,
    output T                       o_dout,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [AW:0] r_wr_cnt;
    logic [AW:0] r_rd_cnt;
    T            r_mem [DEPTH];
    logic        w_do_pop;
    logic        w_do_push;

    assign o_level   = r_wr_cnt - r_rd_cnt;
    assign o_full    = (o_level == FULL_LVL);
    assign o_empty   = (o_level == '0);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = o_empty ? '0 : r_mem[r_rd_cnt[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else if (i_clear) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (w_do_push) r_wr_cnt <= r_wr_cnt + (AW+1)'(1);
            if (w_do_pop)  r_rd_cnt <= r_rd_cnt + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) r_mem[r_wr_cnt[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/root_result_collector.sv
// Collects intersector root pairs: capture, classify hit/miss, order near/far,
// buffer in a FIFO and keep saturating hit/miss/drop statistics.
module root_result_collector
    import root_result_collector_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    root_result_collector_if.slave bus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [CNT_W-1:0]       hit_count,
    output logic [CNT_W-1:0]       miss_count,
    output logic [CNT_W-1:0]       drop_count
);
    logic                     r_s1_v;
    logic [IEEE_argWidth-1:0] r_s1_left;
    logic [IEEE_argWidth-1:0] r_s1_right;
    logic                     r_overflow;
    logic [CNT_W-1:0]         r_hit_count;
    logic [CNT_W-1:0]         r_miss_count;
    logic [CNT_W-1:0]         r_drop_count;

    logic      w_s2_v;
    RootResult w_entry;
    RootResult w_head;
    logic      w_pop;
    logic      w_full;
    logic      w_empty;
    logic      w_accept;
    logic      w_drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_v     <= 1'b0;
            r_s1_left  <= '0;
            r_s1_right <= '0;
        end else if (clear) begin
            r_s1_v     <= 1'b0;
        end else begin
            r_s1_v <= bus.rootsValid;
            if (bus.rootsValid) begin
                r_s1_left  <= bus.leftRoot;
                r_s1_right <= bus.rightRoot;
            end
        end
    end

    // S2 is combinational over the S1 registers so a result lands in the FIFO one edge after capture.
    assign w_s2_v = r_s1_v;

    always_comb begin
        w_entry = '0;
        if (!(is_nan(r_s1_left) || is_nan(r_s1_right))) begin
            w_entry.hit = 1'b1;
            if (order_key(r_s1_left) <= order_key(r_s1_right)) begin
                w_entry.near = r_s1_left;
                w_entry.far  = r_s1_right;
            end else begin
                w_entry.near = r_s1_right;
                w_entry.far  = r_s1_left;
            end
        end
    end

    assign w_pop    = !w_empty && bus.out_ready;
    assign w_accept = w_s2_v && (!w_full || w_pop);
    assign w_drop   = w_s2_v && w_full && !w_pop;

    root_fifo #(
        .DEPTH (DEPTH),
        .T     (RootResult)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_clear (clear),
        .i_push  (w_s2_v),
        .i_pop   (w_pop),
        .i_din   (w_entry),
        .o_dout  (w_head),
        .o_level (level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow   <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_drop_count <= '0;
        end else if (clear) begin
            r_overflow   <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_accept && w_entry.hit && (r_hit_count != '1))
                r_hit_count <= r_hit_count + CNT_W'(1);
            if (w_accept && !w_entry.hit && (r_miss_count != '1))
                r_miss_count <= r_miss_count + CNT_W'(1);
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != '1) r_drop_count <= r_drop_count + CNT_W'(1);
            end
        end
    end

    assign bus.out_valid = !w_empty;
    assign bus.out_hit   = w_head.hit;
    assign bus.out_near  = w_head.near;
    assign bus.out_far   = w_head.far;
    assign overflow      = r_overflow;
    assign hit_count     = r_hit_count;
    assign miss_count    = r_miss_count;
    assign drop_count    = r_drop_count;

endmodule
